// File: rtl/cluster_collector.sv
// cluster_collector: gathers encoder clusters over a fixed window after each
// frame start and publishes them as one registered frame of 14-bit words.
module cluster_collector #(
    parameter int          MXCLUSTERS  = 8,
    parameter int          WINDOW      = 8,
    parameter logic [10:0] INVALID_ADR = 11'h7FE
) (
    input  logic                       clock,
    input  logic                       global_reset,
    input  logic                       frame_start,
    input  logic                       cluster_found,
    input  logic [10:0]                adr,
    input  logic [2:0]                 cnt,
    output logic [14*MXCLUSTERS-1:0]   clusters_out,
    output logic [3:0]                 n_clusters,
    output logic                       overflow,
    output logic                       frame_valid
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [13:0] EMPTY_SLOT = {3'b000, INVALID_ADR};
    localparam logic [3:0]  MAX_FILL   = 4'(MXCLUSTERS);
    localparam logic [3:0]  LAST_IDX   = 4'(WINDOW - 1);

    state_t state, state_next;

    logic [MXCLUSTERS-1:0][13:0] slots, slots_next, cap_slots, pub_slots, pub_words, out_slots;
    logic [3:0] fill, fill_next, cap_fill, pub_fill;
    logic [3:0] win_cnt, win_next;
    logic       ovf_int, ovf_next, cap_ovf, pub_ovf;
    logic       publish;

    // Working buffer as it would look after absorbing this cycle's cluster into the open window
    always_comb begin
        cap_slots = slots;
        cap_fill  = fill;
        cap_ovf   = ovf_int;
        if (state == COLLECT && cluster_found) begin
            if (fill < MAX_FILL) begin
                for (int i = 0; i < MXCLUSTERS; i++) begin
                    if (fill == 4'(i)) begin
                        cap_slots[i] = {cnt, adr};
                    end
                end
                cap_fill = fill + 4'd1;
            end else begin
                cap_ovf = 1'b1;
            end
        end
    end

    // Window sequencing: decides when to publish and how the working buffer restarts
    always_comb begin
        state_next = state;
        win_next   = win_cnt;
        slots_next = cap_slots;
        fill_next  = cap_fill;
        ovf_next   = cap_ovf;
        publish    = 1'b0;
        pub_slots  = cap_slots;
        pub_fill   = cap_fill;
        pub_ovf    = cap_ovf;

        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (frame_start) begin
                    // The restart cycle's cluster belongs to the new window, so the old
                    // window goes out exactly as it stood before this cycle.
                    publish   = 1'b1;
                    pub_slots = slots;
                    pub_fill  = fill;
                    pub_ovf   = ovf_int;
                end else if (win_cnt == LAST_IDX) begin
                    publish    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (frame_start) begin
            win_next = 4'd1;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                slots_next[i] = EMPTY_SLOT;
            end
            fill_next = 4'd0;
            ovf_next  = 1'b0;
            if (cluster_found) begin
                slots_next[0] = {cnt, adr};
                fill_next     = 4'd1;
            end
        end else if (state == COLLECT) begin
            win_next = (state_next == IDLE) ? 4'd0 : win_cnt + 4'd1;
        end
    end

    // Published words: anything beyond the fill level is forced to the invalid marker
    always_comb begin
        pub_words = '0;
        for (int i = 0; i < MXCLUSTERS; i++) begin
            pub_words[i] = (4'(i) < pub_fill) ? pub_slots[i] : EMPTY_SLOT;
        end
    end

    // Control state and working buffer registers
    always_ff @(posedge clock) begin
        if (global_reset) begin
            state   <= IDLE;
            slots   <= {MXCLUSTERS{EMPTY_SLOT}};
            fill    <= 4'd0;
            ovf_int <= 1'b0;
            win_cnt <= 4'd0;
        end else begin
            state   <= state_next;
            slots   <= slots_next;
            fill    <= fill_next;
            ovf_int <= ovf_next;
            win_cnt <= win_next;
        end
    end

    // Output frame registers; they hold between publish strobes
    always_ff @(posedge clock) begin
        if (global_reset) begin
            out_slots   <= {MXCLUSTERS{EMPTY_SLOT}};
            n_clusters  <= 4'd0;
            overflow    <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= publish;
            if (publish) begin
                out_slots  <= pub_words;
                n_clusters <= pub_fill;
                overflow   <= pub_ovf;
            end
        end
    end

    assign clusters_out = out_slots;

endmodule
